// File: rtl/saturn_phase_gen_if.sv
// Bundle of the sequencer's control inputs and status outputs.
// The master side (core/testbench) drives the controls and observes status;
// the slave side is the phase generator itself.
interface saturn_phase_gen_if #(
  parameter int PHASE_BITS = 2,
  parameter int NUM_EN     = 4,
  parameter int CTR_W      = 32
);
  // Control inputs to the sequencer.
  logic                  i_stall;
  logic                  i_halt_req;
  logic                  i_step_mode;
  logic                  i_step;
  logic [CTR_W-1:0]      i_max_cycle;

  // Registered status outputs from the sequencer.
  logic [PHASE_BITS-1:0] o_phase;
  logic [NUM_EN-1:0]     o_en;
  logic [CTR_W-1:0]      o_cycle;
  logic [1:0]            o_state;
  logic                  o_halt;
  logic [1:0]            o_halt_cause;

  modport master (
    output i_stall, i_halt_req, i_step_mode, i_step, i_max_cycle,
    input  o_phase, o_en, o_cycle, o_state, o_halt, o_halt_cause
  );

  modport slave (
    input  i_stall, i_halt_req, i_step_mode, i_step, i_max_cycle,
    output o_phase, o_en, o_cycle, o_state, o_halt, o_halt_cause
  );
endinterface

// File: rtl/saturn_phase_gen.sv
// Saturn phase-enable generator.
// Divides i_clk into a 2^PHASE_BITS-phase instruction cycle, emits one-cycle
// enable strobes on mapped phases, counts instruction cycles, and supports
// stall hold, single-step pausing, a cycle budget and a sticky halt state.
//
// Control semantics: every control on the interface is level-sampled on each
// rising edge of i_clk; there is no handshake. A "hold" keeps phase and cycle
// count and forces all enables low; an "advance" moves to the next phase and
// raises exactly the enables mapped to it.
module saturn_phase_gen #(
  parameter int                               PHASE_BITS   = 2,
  parameter int                               NUM_EN       = 4,
  parameter logic [NUM_EN*PHASE_BITS-1:0]     EN_PHASE_MAP = {2'd3, 2'd2, 2'd1, 2'd0},
  parameter int                               CYCLE_PHASE  = 0,
  parameter int                               CTR_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  saturn_phase_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_REQ    = 2'd1,
    CAUSE_BUDGET = 2'd2
  } cause_t;

  localparam logic [PHASE_BITS-1:0] LAST_PH = '1;
  localparam logic [PHASE_BITS-1:0] CYC_PH  = PHASE_BITS'(CYCLE_PHASE);

  // Registered state and outputs.
  state_t                state_q;
  cause_t                cause_q;
  logic [PHASE_BITS-1:0] phase_q;
  logic [NUM_EN-1:0]     en_q;
  logic [CTR_W-1:0]      cycle_q;
  logic                  halt_q;

  // Values an advance would load this edge.
  logic [PHASE_BITS-1:0] phase_adv;
  logic [NUM_EN-1:0]     en_adv;
  logic                  enter_cycle;
  logic                  budget_hit;

  assign phase_adv   = phase_q + 1'b1;
  assign enter_cycle = (phase_adv == CYC_PH);

  // A budget hit stops the machine right before it would start cycle
  // i_max_cycle+1, so cycles 0..i_max_cycle all get to run.
  assign budget_hit  = (bus.i_max_cycle != '0) && enter_cycle &&
                       (cycle_q == bus.i_max_cycle);

  // Decode which enables belong to the phase being entered.
  always_comb begin
    en_adv = '0;
    for (int k = 0; k < NUM_EN; k++) begin
      en_adv[k] = (phase_adv == EN_PHASE_MAP[k*PHASE_BITS +: PHASE_BITS]);
    end
  end

  // Sequencer FSM: state, phase, enables, counter and halt status in one place.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      cause_q <= CAUSE_NONE;
      phase_q <= '1;
      en_q    <= '0;
      cycle_q <= '1;
      halt_q  <= 1'b0;
    end else begin
      // Every path that does not advance is a hold, so enables default low.
      en_q <= '0;
      case (state_q)
        ST_RUN: begin
          if (bus.i_halt_req) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_REQ;
            halt_q  <= 1'b1;
          end else if (budget_hit) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_BUDGET;
            halt_q  <= 1'b1;
          end else if (bus.i_stall) begin
            // hold
          end else if (bus.i_step_mode && (phase_q == LAST_PH)) begin
            state_q <= ST_PAUSED;
          end else begin
            phase_q <= phase_adv;
            en_q    <= en_adv;
            if (enter_cycle) cycle_q <= cycle_q + 1'b1;
          end
        end

        ST_PAUSED: begin
          if (bus.i_halt_req) begin
            state_q <= ST_HALTED;
            cause_q <= CAUSE_REQ;
            halt_q  <= 1'b1;
          end else if (bus.i_stall) begin
            // A step seen during a stall is dropped, not remembered.
          end else if (bus.i_step || !bus.i_step_mode) begin
            if (budget_hit) begin
              state_q <= ST_HALTED;
              cause_q <= CAUSE_BUDGET;
              halt_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              phase_q <= phase_adv;
              en_q    <= en_adv;
              if (enter_cycle) cycle_q <= cycle_q + 1'b1;
            end
          end
        end

        default: begin
          // HALTED is sticky; only reset leaves it.
          state_q <= ST_HALTED;
          halt_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_phase      = phase_q;
  assign bus.o_en         = en_q;
  assign bus.o_cycle      = cycle_q;
  assign bus.o_state      = state_q;
  assign bus.o_halt       = halt_q;
  assign bus.o_halt_cause = cause_q;

endmodule

// File: tb/tb_saturn_phase_gen.sv
// Directed bench for saturn_phase_gen: the driver applies one input vector per
// edge and queues the hand-computed outputs; the monitor pops and compares
// after every rising edge.
module tb_saturn_phase_gen;

  localparam int EW = 2 + 4 + 32 + 2 + 1 + 2;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [1:0]  RUN = 2'd0, PAU = 2'd1, HLT = 2'd2;

  logic clk;
  logic rst;

  saturn_phase_gen_if #(.PHASE_BITS(2), .NUM_EN(4), .CTR_W(32)) bus ();

  saturn_phase_gen dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard.
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  // Drive one input vector at the falling edge; queue what the next rising
  // edge must produce.
  task automatic cyc(input string nm, input bit r, input bit st, input bit hr,
                     input bit sm, input bit sp, input logic [31:0] maxc,
                     input logic [1:0] ph, input logic [3:0] en,
                     input logic [31:0] cy, input logic [1:0] state,
                     input logic [1:0] cause);
    @(negedge clk);
    rst             = r;
    bus.i_stall     = st;
    bus.i_halt_req  = hr;
    bus.i_step_mode = sm;
    bus.i_step      = sp;
    bus.i_max_cycle = maxc;
    exp_q.push_back({ph, en, cy, state, (state == HLT), cause});
    name_q.push_back(nm);
  endtask

  // Monitor: compare after each rising edge whenever an expectation is queued.
  always @(posedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    string         nm;
    #2;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {bus.o_phase, bus.o_en, bus.o_cycle, bus.o_state, bus.o_halt,
               bus.o_halt_cause};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else
        $display("FAIL %s: got ph=%0d en=%b cy=%h st=%0d halt=%b cause=%0d, want ph=%0d en=%b cy=%h st=%0d halt=%b cause=%0d",
                 nm, act_v[42:41], act_v[40:37], act_v[36:5], act_v[4:3], act_v[2], act_v[1:0],
                 exp_v[42:41], exp_v[40:37], exp_v[36:5], exp_v[4:3], exp_v[2], exp_v[1:0]);
    end
  end

  initial begin
    int budget;
    rst = 1'b1;
    bus.i_stall = 1'b0; bus.i_halt_req = 1'b0; bus.i_step_mode = 1'b0;
    bus.i_step = 1'b0; bus.i_max_cycle = '0;

    // Reset values, then free-running sequence.
    repeat (3) cyc("reset", 1,0,0,0,0, 0, 2'd3, 4'b0000, ONES, RUN, 0);
    cyc("run_p0", 0,0,0,0,0, 0, 2'd0, 4'b0001, 32'd0, RUN, 0);
    cyc("run_p1", 0,0,0,0,0, 0, 2'd1, 4'b0010, 32'd0, RUN, 0);
    cyc("run_p2", 0,0,0,0,0, 0, 2'd2, 4'b0100, 32'd0, RUN, 0);
    cyc("run_p3", 0,0,0,0,0, 0, 2'd3, 4'b1000, 32'd0, RUN, 0);
    cyc("run_c1", 0,0,0,0,0, 0, 2'd0, 4'b0001, 32'd1, RUN, 0);

    // Stall at phase 1 for three edges.
    cyc("pre_stall", 0,0,0,0,0, 0, 2'd1, 4'b0010, 32'd1, RUN, 0);
    repeat (3) cyc("stall_hold", 0,1,0,0,0, 0, 2'd1, 4'b0000, 32'd1, RUN, 0);
    cyc("stall_rel", 0,0,0,0,0, 0, 2'd2, 4'b0100, 32'd1, RUN, 0);
    cyc("stall_p3", 0,0,0,0,0, 0, 2'd3, 4'b1000, 32'd1, RUN, 0);

    // Halt request sampled at phase 1.
    cyc("c2_p0", 0,0,0,0,0, 0, 2'd0, 4'b0001, 32'd2, RUN, 0);
    cyc("c2_p1", 0,0,0,0,0, 0, 2'd1, 4'b0010, 32'd2, RUN, 0);
    cyc("halt_req", 0,0,1,0,0, 0, 2'd1, 4'b0000, 32'd2, HLT, 1);
    repeat (5) cyc("halt_sticky", 0,1,0,0,1, 0, 2'd1, 4'b0000, 32'd2, HLT, 1);
    cyc("halt_reset", 1,0,0,0,0, 0, 2'd3, 4'b0000, ONES, RUN, 0);

    // Budget of 2: cycles 0..2 run, then halt on the would-be 3->0 edge.
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 4; p++)
        cyc("budget_run", 0,0,0,0,0, 32'd2, 2'(p), 4'(1 << p), 32'(c), RUN, 0);
    cyc("budget_hit", 0,0,0,0,0, 32'd2, 2'd3, 4'b0000, 32'd2, HLT, 2);
    repeat (20) cyc("budget_hold", 0,0,0,0,0, 32'd2, 2'd3, 4'b0000, 32'd2, HLT, 2);
    cyc("budget_reset", 1,0,0,1,0, 0, 2'd3, 4'b0000, ONES, RUN, 0);

    // Single-step mode held through reset.
    cyc("step_pause", 0,0,0,1,0, 0, 2'd3, 4'b0000, ONES, PAU, 0);
    cyc("step_idle", 0,0,0,1,0, 0, 2'd3, 4'b0000, ONES, PAU, 0);
    cyc("step_p0", 0,0,0,1,1, 0, 2'd0, 4'b0001, 32'd0, RUN, 0);
    cyc("step_p1", 0,0,0,1,0, 0, 2'd1, 4'b0010, 32'd0, RUN, 0);
    cyc("step_p2", 0,0,0,1,0, 0, 2'd2, 4'b0100, 32'd0, RUN, 0);
    cyc("step_p3", 0,0,0,1,0, 0, 2'd3, 4'b1000, 32'd0, RUN, 0);
    cyc("step_repause", 0,0,0,1,0, 0, 2'd3, 4'b0000, 32'd0, PAU, 0);
    cyc("step_stalled", 0,1,0,1,1, 0, 2'd3, 4'b0000, 32'd0, PAU, 0);
    cyc("step_dropped", 0,0,0,1,0, 0, 2'd3, 4'b0000, 32'd0, PAU, 0);
    cyc("step2_p0", 0,0,0,1,1, 0, 2'd0, 4'b0001, 32'd1, RUN, 0);
    cyc("step2_p1", 0,0,0,1,0, 0, 2'd1, 4'b0010, 32'd1, RUN, 0);
    cyc("step2_p2", 0,0,0,1,0, 0, 2'd2, 4'b0100, 32'd1, RUN, 0);
    cyc("step2_p3", 0,0,0,1,0, 0, 2'd3, 4'b1000, 32'd1, RUN, 0);
    cyc("step2_pause", 0,0,0,1,0, 0, 2'd3, 4'b0000, 32'd1, PAU, 0);
    cyc("resume_p0", 0,0,0,0,0, 0, 2'd0, 4'b0001, 32'd2, RUN, 0);
    cyc("resume_p1", 0,0,0,0,0, 0, 2'd1, 4'b0010, 32'd2, RUN, 0);
    cyc("resume_p2", 0,0,0,0,0, 0, 2'd2, 4'b0100, 32'd2, RUN, 0);

    // Reset mid-run at phase 2.
    cyc("midrun_reset", 1,1,0,0,0, 0, 2'd3, 4'b0000, ONES, RUN, 0);
    cyc("post_reset_p0", 0,0,0,0,0, 0, 2'd0, 4'b0001, 32'd0, RUN, 0);

    // Halt request while paused.
    cyc("pause_reset", 1,0,0,1,0, 0, 2'd3, 4'b0000, ONES, RUN, 0);
    cyc("pause_enter", 0,0,0,1,0, 0, 2'd3, 4'b0000, ONES, PAU, 0);
    cyc("pause_halt", 0,0,1,1,1, 0, 2'd3, 4'b0000, ONES, HLT, 1);
    cyc("pause_halt_hold", 0,0,0,0,0, 0, 2'd3, 4'b0000, ONES, HLT, 1);

    // Let the monitor drain the queue, bounded.
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
